wptr_gray_ctrl: RTL and testbench

WPTR_GRAY_CTRL -- requirements
Module: wptr_gray_ctrl

---
 rtl/wptr_gray_ctrl.sv | 152 +++++++++++++++
 tb/tb_wptr_gray_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wptr_gray_ctrl.sv
// ---------------------------------------------------------------------------
// wptr_gray_ctrl
//
// Write-side pointer controller for an asynchronous FIFO. Keeps the binary
// write pointer, publishes its Gray-coded copy to the read domain, brings the
// read domain's Gray pointer across through a flop synchronizer, and derives
// full / almost-full / occupancy / sticky-overflow status.
//
// Parameters
//   ADDR_WIDTH  : FIFO depth is 2**ADDR_WIDTH entries
//   SYNC_STAGES : flops in the read-pointer synchronizer (2..4)
//   AFULL_LVL   : occupancy at which walmost_full asserts (1..2**ADDR_WIDTH)
//
// Ports
//   wclk         in   write clock (only clock of this block)
//   wrst_n       in   synchronous active-low reset
//   winc         in   write request
//   rptr_gray    in   Gray read pointer, asynchronous to wclk
//   wovf_clr     in   clear for the sticky overflow flag
//   waddr        out  RAM write address
//   wptr_gray    out  Gray write pointer for the read domain
//   wfull        out  FIFO full
//   walmost_full out  occupancy >= AFULL_LVL
//   wlevel       out  write-side occupancy, 0..2**ADDR_WIDTH
//   wovf         out  sticky overflow (write attempted while full)
//
// Every output comes straight from a flop; the "next" values are computed
// from the post-write pointer so that status reflects an accepted write on
// the same edge that accepts it.
// ---------------------------------------------------------------------------
module wptr_gray_ctrl #(
  parameter int ADDR_WIDTH  = 3,
  parameter int SYNC_STAGES = 2,
  parameter int AFULL_LVL   = 6
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  winc,
  input  logic [ADDR_WIDTH:0]   rptr_gray,
  input  logic                  wovf_clr,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr_gray,
  output logic                  wfull,
  output logic                  walmost_full,
  output logic [ADDR_WIDTH:0]   wlevel,
  output logic                  wovf
);

  localparam int PTR_W = ADDR_WIDTH + 1;

  // Full means the write pointer is exactly one lap ahead of the read
  // pointer. In Gray code that is "top two bits inverted, rest equal".
  localparam logic [PTR_W-1:0] FULL_MASK = PTR_W'(3) << (ADDR_WIDTH - 1);

  localparam logic [PTR_W-1:0] AFULL_THR = PTR_W'(AFULL_LVL);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [PTR_W-1:0] wbin_reg;
  logic [PTR_W-1:0] wgray_reg;
  logic [PTR_W-1:0] wlevel_reg;
  logic             wfull_reg;
  logic             wafull_reg;
  logic             wovf_reg;

  // Read-pointer synchronizer; index 0 is the flop that samples rptr_gray.
  logic [SYNC_STAGES-1:0][PTR_W-1:0] sync_reg;

  // -------------------------------------------------------------------------
  // Combinational next-state
  // -------------------------------------------------------------------------
  logic [PTR_W-1:0] rq_gray;
  logic [PTR_W-1:0] rq_bin;
  logic             wen;
  logic [PTR_W-1:0] wbin_next;
  logic [PTR_W-1:0] wgray_next;
  logic [PTR_W-1:0] wlevel_next;
  logic             wfull_next;
  logic             wafull_next;
  logic             ovf_set;
  logic             wovf_next;

  assign rq_gray = sync_reg[SYNC_STAGES-1];

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above
  // it. Written as an independent reduction per bit so no bit of rq_bin
  // depends on another bit of rq_bin.
  generate
    for (genvar gi = 0; gi < PTR_W; gi++) begin : g_rq_bin
      assign rq_bin[gi] = ^rq_gray[ADDR_WIDTH:gi];
    end
  endgenerate

  always_comb begin
    wen         = winc & ~wfull_reg;
    wbin_next   = wbin_reg + PTR_W'(wen);
    wgray_next  = wbin_next ^ (wbin_next >> 1);
    // Modular subtraction is correct across the pointer rollover because
    // the pointers carry one extra lap bit.
    wlevel_next = wbin_next - rq_bin;
    wfull_next  = (wgray_next == (rq_gray ^ FULL_MASK));
    // A full FIFO has level 2**ADDR_WIDTH >= AFULL_LVL, so almost-full is
    // always set alongside full.
    wafull_next = (wlevel_next >= AFULL_THR);
    // New overflow takes priority over a clear on the same edge.
    ovf_set     = winc & wfull_reg;
    wovf_next   = ovf_set | (wovf_reg & ~wovf_clr);
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      sync_reg <= '0;
    end else if (SYNC_STAGES == 1) begin
      sync_reg <= rptr_gray;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], rptr_gray};
    end
  end

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      wbin_reg   <= '0;
      wgray_reg  <= '0;
      wlevel_reg <= '0;
      wfull_reg  <= 1'b0;
      wafull_reg <= 1'b0;
      wovf_reg   <= 1'b0;
    end else begin
      wbin_reg   <= wbin_next;
      wgray_reg  <= wgray_next;
      wlevel_reg <= wlevel_next;
      wfull_reg  <= wfull_next;
      wafull_reg <= wafull_next;
      wovf_reg   <= wovf_next;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs (flop-driven only)
  // -------------------------------------------------------------------------
  assign waddr        = wbin_reg[ADDR_WIDTH-1:0];
  assign wptr_gray    = wgray_reg;
  assign wlevel       = wlevel_reg;
  assign wfull        = wfull_reg;
  assign walmost_full = wafull_reg;
  assign wovf         = wovf_reg;

endmodule

// File: tb/tb_wptr_gray_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for wptr_gray_ctrl (ADDR_WIDTH=3, SYNC_STAGES=2, AFULL_LVL=6).
// The reference model counts writes and reads as plain integers; the read
// pointer the DUT sees is the bench's read count from SYNC_STAGES edges
// earlier, and every status flag follows from their difference.
// ---------------------------------------------------------------------------
module tb_wptr_gray_ctrl;

  localparam int AW    = 3;
  localparam int SYNC  = 2;
  localparam int AFULL = 6;
  localparam int DEPTH = 1 << AW;

  logic          wclk;
  logic          wrst_n;
  logic          winc;
  logic [AW:0]   rptr_gray;
  logic          wovf_clr;
  logic [AW-1:0] waddr;
  logic [AW:0]   wptr_gray;
  logic          wfull;
  logic          walmost_full;
  logic [AW:0]   wlevel;
  logic          wovf;

  wptr_gray_ctrl #(
    .ADDR_WIDTH (AW),
    .SYNC_STAGES(SYNC),
    .AFULL_LVL  (AFULL)
  ) dut (
    .wclk        (wclk),
    .wrst_n      (wrst_n),
    .winc        (winc),
    .rptr_gray   (rptr_gray),
    .wovf_clr    (wovf_clr),
    .waddr       (waddr),
    .wptr_gray   (wptr_gray),
    .wfull       (wfull),
    .walmost_full(walmost_full),
    .wlevel      (wlevel),
    .wovf        (wovf)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  // Counters
  int n_checks = 0;
  int n_fail   = 0;
  int n_tick   = 0;

  // Reference model: unbounded write count, read count, delayed read view
  int   m_w     = 0;
  int   m_level = 0;
  logic m_full  = 1'b0;
  logic m_afull = 1'b0;
  logic m_ovf   = 1'b0;
  int   hist[$];
  int   r_cnt   = 0;

  function automatic logic [AW:0] to_gray(input int v);
    logic [AW:0] b;
    b = (AW+1)'(v);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [13:0] exp_vec();
    logic [AW:0] wb;
    wb = (AW+1)'(m_w);
    return {to_gray(m_w), wb[AW-1:0], (AW+1)'(m_level), m_full, m_afull, m_ovf};
  endfunction

  function automatic logic [13:0] obs_vec();
    return {wptr_gray, waddr, wlevel, wfull, walmost_full, wovf};
  endfunction

  // One clock edge: drive inputs, advance the model, settle, log.
  task automatic tick(input logic inc, input logic clr, input logic rst_n);
    int   r_seen;
    logic set;
    winc      = inc;
    wovf_clr  = clr;
    wrst_n    = rst_n;
    rptr_gray = to_gray(r_cnt);
    @(posedge wclk);
    if (!rst_n) begin
      m_w = 0; m_level = 0; m_full = 1'b0; m_afull = 1'b0; m_ovf = 1'b0;
      hist.delete();
      for (int i = 0; i < SYNC; i++) hist.push_back(0);
    end else begin
      r_seen = hist.pop_front();
      hist.push_back(r_cnt);
      set = inc && m_full;
      if (inc && !m_full) m_w++;
      m_level = m_w - r_seen;
      m_full  = (m_level == DEPTH);
      m_afull = (m_level >= AFULL);
      m_ovf   = set || (m_ovf && !clr);
    end
    #1;
    n_tick++;
    $display("tick %0d: winc=%0b clr=%0b rst_n=%0b rptr_gray=%b -> wptr_gray=%b waddr=%0d wlevel=%0d wfull=%0b afull=%0b wovf=%0b",
             n_tick, inc, clr, rst_n, rptr_gray, wptr_gray, waddr, wlevel, wfull, walmost_full, wovf);
  endtask

  task automatic test_reset();
    r_cnt = 0;
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, 1'b1, 1'b0);
      n_checks++;
      if (obs_vec() !== 14'd0) begin
        n_fail++;
        $display("FAIL reset_zero: got %b want %b", obs_vec(), 14'd0);
      end
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= DEPTH; i++) begin
      tick(1'b1, 1'b0, 1'b1);
      n_checks++;
      if (wlevel !== (AW+1)'(i)) begin
        n_fail++;
        $display("FAIL fill_level: write %0d got %0d want %0d", i, wlevel, i);
      end
      n_checks++;
      if (walmost_full !== (i >= AFULL) || wfull !== (i == DEPTH)) begin
        n_fail++;
        $display("FAIL fill_flags: write %0d got afull=%0b full=%0b want afull=%0b full=%0b",
                 i, walmost_full, wfull, (i >= AFULL), (i == DEPTH));
      end
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL fill_model: got %b want %b", obs_vec(), exp_vec());
      end
    end
    n_checks++;
    if (wptr_gray !== 4'b1100 || waddr !== 3'd0) begin
      n_fail++;
      $display("FAIL fill_end_ptr: got wptr_gray=%b waddr=%0d want 1100 and 0", wptr_gray, waddr);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, 1'b0, 1'b1);
      n_checks++;
      if (wptr_gray !== 4'b1100 || wovf !== 1'b1 || waddr !== 3'd0) begin
        n_fail++;
        $display("FAIL ovf_hold: got wptr_gray=%b waddr=%0d wovf=%0b want 1100 0 1", wptr_gray, waddr, wovf);
      end
    end
    tick(1'b0, 1'b1, 1'b1);
    n_checks++;
    if (wovf !== 1'b0 || obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL ovf_clear: got %b want %b", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_same_edge_ovf();
    tick(1'b1, 1'b1, 1'b1);
    n_checks++;
    if (wovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set_wins: got wovf=%0b want 1", wovf);
    end
    tick(1'b0, 1'b1, 1'b1);
    n_checks++;
    if (wovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear2: got wovf=%0b want 0", wovf);
    end
  endtask

  task automatic test_release();
    r_cnt = 1;  // Gray 0001
    for (int i = 1; i <= SYNC + 1; i++) begin
      tick(1'b0, 1'b0, 1'b1);
      n_checks++;
      if (i <= SYNC) begin
        if (wfull !== 1'b1 || wlevel !== 4'd8) begin
          n_fail++;
          $display("FAIL release_early: edge %0d got full=%0b level=%0d want 1 8", i, wfull, wlevel);
        end
      end else begin
        if (wfull !== 1'b0 || wlevel !== 4'd7 || walmost_full !== 1'b1) begin
          n_fail++;
          $display("FAIL release_latency: edge %0d got full=%0b level=%0d afull=%0b want 0 7 1",
                   i, wfull, wlevel, walmost_full);
        end
      end
    end
  endtask

  task automatic test_reset_while_full();
    tick(1'b1, 1'b0, 1'b1);  // refills to 8
    n_checks++;
    if (wfull !== 1'b1 || obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL refill: got %b want %b", obs_vec(), exp_vec());
    end
    tick(1'b1, 1'b0, 1'b1);  // overflow
    n_checks++;
    if (wovf !== 1'b1) begin
      n_fail++;
      $display("FAIL refill_ovf: got wovf=%0b want 1", wovf);
    end
    r_cnt = 0;
    tick(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (obs_vec() !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_while_full: got %b want %b", obs_vec(), 14'd0);
    end
  endtask

  task automatic test_wrap_tracking();
    int          dq[$];
    int          wraps;
    logic [AW:0] prev;
    wraps = 0;
    for (int i = 0; i < 4; i++) dq.push_back(m_w);
    for (int i = 0; i < 40; i++) begin
      prev  = wptr_gray;
      r_cnt = dq.pop_front();
      tick(1'b1, 1'b0, 1'b1);
      dq.push_back(m_w);
      if (prev == 4'b1000 && wptr_gray == 4'b0000) wraps++;
      n_checks++;
      if ($countones(prev ^ wptr_gray) != 1 || wfull !== 1'b0) begin
        n_fail++;
        $display("FAIL wrap_step: write %0d prev=%b now=%b full=%0b want one-bit change, not full",
                 i, prev, wptr_gray, wfull);
      end
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL wrap_model: got %b want %b", obs_vec(), exp_vec());
      end
    end
    n_checks++;
    if (wraps != 2) begin
      n_fail++;
      $display("FAIL wrap_count: got %0d want 2", wraps);
    end
  endtask

  task automatic test_random();
    logic inc, clr, rst_n;
    for (int i = 0; i < 300; i++) begin
      inc   = ($urandom_range(0, 3) != 0);
      clr   = ($urandom_range(0, 7) == 0);
      rst_n = ($urandom_range(0, 99) != 0);
      if (!rst_n) r_cnt = 0;
      else if (r_cnt < m_w && $urandom_range(0, 2) == 0) r_cnt++;
      tick(inc, clr, rst_n);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random_model: step %0d got %b want %b", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    wrst_n    = 1'b0;
    winc      = 1'b0;
    wovf_clr  = 1'b0;
    rptr_gray = '0;
    for (int i = 0; i < SYNC; i++) hist.push_back(0);
    test_reset();
    test_fill();
    test_overflow();
    test_same_edge_ovf();
    test_release();
    test_reset_while_full();
    test_wrap_tracking();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
